// File: rtl/fetch_ref_chroma_pp.sv
// rtl/fetch_ref_chroma_pp.sv - ping-pong chroma reference window buffer with vertical clamp and x range handling
// Optional: FETCH_CHROMA_XCLAMP_EN saturates x so every read returns OUT_PELS stored pixels.
module fetch_ref_chroma_pp #(
  parameter int PIXEL_WIDTH = 8,
  parameter int NCH         = 2,
  parameter int WIN_W       = 48,
  parameter int WIN_H       = 48,
  parameter int PAD_TOP     = 8,
  parameter int OUT_PELS    = 8,
  parameter int Y_WIDTH     = 9,
  localparam int AW = $clog2(WIN_H),
  localparam int XW = $clog2(WIN_W),
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 sysif_start_i,
  input  logic [Y_WIDTH-1:0]                   sysif_total_y_i,
  input  logic [Y_WIDTH-1:0]                   mc_cur_y_i,
  input  logic                                 mc_ref_rden_i,
  input  logic [CW-1:0]                        mc_ref_sel_i,
  input  logic [XW-1:0]                        mc_ref_x_i,
  input  logic [AW-1:0]                        mc_ref_y_i,
  output logic [OUT_PELS*PIXEL_WIDTH-1:0]      mc_ref_pel_o,
  output logic                                 mc_ref_valid_o,
  input  logic                                 ext_load_valid_i,
  input  logic [AW-1:0]                        ext_load_addr_i,
  input  logic [NCH*WIN_W*PIXEL_WIDTH-1:0]     ext_load_data_i,
  input  logic                                 ext_load_done_i,
  output logic                                 load_bank_o,
  output logic                                 ref_ready_o,
  output logic                                 rd_err_o
);

  localparam int PLANE_W = WIN_W * PIXEL_WIDTH;
  localparam int ROW_W   = NCH * PLANE_W;
  localparam int OUT_W   = OUT_PELS * PIXEL_WIDTH;

  logic [ROW_W-1:0] mem [0:1][0:WIN_H-1];

  logic             wr_bank, wr_n;
  logic [1:0]       loaded, loaded_n;
  logic             rd_err;
  logic [AW-1:0]    ye;
  logic             ye_ok, wr_ok, sel_bad, err_set;
  logic [XW-1:0]    x_eff, x_q;
  logic [ROW_W-1:0] row_rd;
  logic [PLANE_W-1:0] plane_rd, plane_q;
  logic [XW:0]      idx;

  // Bank bookkeeping: a done in the start cycle lands on the bank that becomes readable.
  always_comb begin
    wr_n     = wr_bank ^ sysif_start_i;
    loaded_n = loaded;
    if (ext_load_done_i) loaded_n[wr_bank] = 1'b1;
    if (sysif_start_i)   loaded_n[~wr_bank] = 1'b0;
  end

  always_comb begin
    ye = mc_ref_y_i;
    if (mc_cur_y_i == '0) begin
      if (mc_ref_y_i < AW'(PAD_TOP)) ye = '0;
      else                           ye = mc_ref_y_i - AW'(PAD_TOP);
    end else if (mc_cur_y_i == sysif_total_y_i) begin
      if (mc_ref_y_i > AW'(WIN_H - PAD_TOP - 1)) ye = AW'(WIN_H - PAD_TOP - 1);
    end
  end

  assign ye_ok   = ({1'b0, ye} < (AW+1)'(WIN_H));
  assign wr_ok   = ({1'b0, ext_load_addr_i} < (AW+1)'(WIN_H));
  assign sel_bad = ({1'b0, mc_ref_sel_i} >= (CW+1)'(NCH));
  assign err_set = (mc_ref_rden_i && (!ref_ready_o || sel_bad)) ||
                   (ext_load_valid_i && !wr_ok);

`ifdef FETCH_CHROMA_XCLAMP_EN
  assign x_eff = (mc_ref_x_i > XW'(WIN_W - OUT_PELS)) ? XW'(WIN_W - OUT_PELS) : mc_ref_x_i;
`else
  assign x_eff = mc_ref_x_i;
`endif

  assign row_rd = ye_ok ? mem[~wr_bank][ye] : '0;

  always_comb begin
    plane_rd = '0;
    for (int p = 0; p < NCH; p++)
      if ({1'b0, mc_ref_sel_i} == (CW+1)'(p))
        plane_rd = row_rd[ROW_W-1-p*PLANE_W -: PLANE_W];
  end

  always_ff @(posedge clk) begin
    if (ext_load_valid_i && wr_ok) mem[wr_bank][ext_load_addr_i] <= ext_load_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank        <= 1'b0;
      loaded         <= 2'b00;
      rd_err         <= 1'b0;
      load_bank_o    <= 1'b0;
      ref_ready_o    <= 1'b0;
      mc_ref_valid_o <= 1'b0;
      plane_q        <= '0;
      x_q            <= '0;
    end else begin
      wr_bank        <= wr_n;
      loaded         <= loaded_n;
      load_bank_o    <= wr_n;
      ref_ready_o    <= loaded_n[~wr_n];
      mc_ref_valid_o <= mc_ref_rden_i;
      if (err_set) rd_err <= 1'b1;
      if (mc_ref_rden_i) begin
        plane_q <= plane_rd;
        x_q     <= x_eff;
      end
    end
  end

  // Lanes past the window edge read as zero; with x saturation they never occur.
  always_comb begin
    mc_ref_pel_o = '0;
    idx          = '0;
    for (int k = 0; k < OUT_PELS; k++) begin
      idx = {1'b0, x_q} + (XW+1)'(k);
      if (idx < (XW+1)'(WIN_W))
        mc_ref_pel_o[OUT_W-1-k*PIXEL_WIDTH -: PIXEL_WIDTH] =
          plane_q[PLANE_W-1-int'(idx)*PIXEL_WIDTH -: PIXEL_WIDTH];
    end
  end

  assign rd_err_o = rd_err;

endmodule

// File: tb/tb_fetch_ref_chroma_pp.sv
// tb/tb_fetch_ref_chroma_pp.sv - directed self-checking bench for fetch_ref_chroma_pp
// Honours FETCH_CHROMA_XCLAMP_EN for the x range expectations.
module tb_fetch_ref_chroma_pp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start, done, ld_valid, rden;
  logic [8:0]   total_y, cur_y;
  logic         sel;
  logic [5:0]   x, y, ld_addr;
  logic [767:0] ld_data;
  logic [63:0]  pel;
  logic         valid, load_bank, ready, rd_err;

  logic          start3, done3, ld_valid3, rden3;
  logic [1:0]    sel3;
  logic [5:0]    x3, y3, ld_addr3;
  logic [1151:0] ld_data3;
  logic [63:0]   pel3;
  logic          valid3, load_bank3, ready3, rd_err3;

  int n_cmp = 0;
  int n_mis = 0;

  fetch_ref_chroma_pp u_dut (
    .clk(clk), .rst(rst), .sysif_start_i(start), .sysif_total_y_i(total_y),
    .mc_cur_y_i(cur_y), .mc_ref_rden_i(rden), .mc_ref_sel_i(sel), .mc_ref_x_i(x),
    .mc_ref_y_i(y), .mc_ref_pel_o(pel), .mc_ref_valid_o(valid),
    .ext_load_valid_i(ld_valid), .ext_load_addr_i(ld_addr), .ext_load_data_i(ld_data),
    .ext_load_done_i(done), .load_bank_o(load_bank), .ref_ready_o(ready), .rd_err_o(rd_err)
  );

  fetch_ref_chroma_pp #(.NCH(3)) u_dut3 (
    .clk(clk), .rst(rst), .sysif_start_i(start3), .sysif_total_y_i(total_y),
    .mc_cur_y_i(cur_y), .mc_ref_rden_i(rden3), .mc_ref_sel_i(sel3), .mc_ref_x_i(x3),
    .mc_ref_y_i(y3), .mc_ref_pel_o(pel3), .mc_ref_valid_o(valid3),
    .ext_load_valid_i(ld_valid3), .ext_load_addr_i(ld_addr3), .ext_load_data_i(ld_data3),
    .ext_load_done_i(done3), .load_bank_o(load_bank3), .ref_ready_o(ready3), .rd_err_o(rd_err3)
  );

  function automatic logic [7:0] pix(int tag, int p, int r, int c);
    return 8'((tag * 97 + p * 61 + r * 7 + c * 3) & 255);
  endfunction

  function automatic logic [1151:0] row3(int tag, int r);
    logic [1151:0] v;
    v = '0;
    for (int p = 0; p < 3; p++)
      for (int c = 0; c < 48; c++)
        v[1151 - p*384 - c*8 -: 8] = pix(tag, p, r, c);
    return v;
  endfunction

  function automatic logic [63:0] exp_pel(int tag, int p, int r, int xin);
    logic [63:0] v;
    int xs;
    xs = xin;
`ifdef FETCH_CHROMA_XCLAMP_EN
    if (xs > 40) xs = 40;
`endif
    v = '0;
    for (int k = 0; k < 8; k++)
      v[63 - k*8 -: 8] = (xs + k < 48) ? pix(tag, p, r, xs + k) : 8'h00;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int s, input int yy, input int xx);
    rden = 1'b1; sel = s[0]; y = 6'(yy); x = 6'(xx);
  endtask

  logic [1151:0] tmp;

  initial begin
    start = 0; done = 0; ld_valid = 0; rden = 0; total_y = 9'd7; cur_y = 9'd1;
    sel = 0; x = 0; y = 0; ld_addr = 0; ld_data = '0;
    start3 = 0; done3 = 0; ld_valid3 = 0; rden3 = 0; sel3 = 0; x3 = 0; y3 = 0;
    ld_addr3 = 0; ld_data3 = '0;
    tick; tick;
    rst = 1'b0;
    tick;
    chk("rst_pel", pel, 64'h0);
    chk("rst_valid", 64'(valid), 64'h0);
    chk("rst_load_bank", 64'(load_bank), 64'h0);
    chk("rst_ready", 64'(ready), 64'h0);
    chk("rst_err", 64'(rd_err), 64'h0);

    for (int r = 0; r < 48; r++) begin
      ld_valid = 1'b1; ld_addr = 6'(r); tmp = row3(0, r); ld_data = tmp[1151:384];
      tick;
    end
    ld_valid = 1'b0; done = 1'b1;
    tick;
    done = 1'b0;
    chk("done_ready_before_start", 64'(ready), 64'h0);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_load_bank", 64'(load_bank), 64'h1);
    chk("start_ready", 64'(ready), 64'h1);

    rd(1, 5, 0);
    tick;
    rden = 1'b0;
    chk("rd_valid", 64'(valid), 64'h1);
    chk("rd_sel1_y5", pel, 64'h606366696C6F7275);
    tick;
    chk("rd_valid_pulse", 64'(valid), 64'h0);
    chk("rd_pel_hold", pel, 64'h606366696C6F7275);

    cur_y = 9'd0;
    rd(0, 3, 0); tick; chk("top_y3", pel, exp_pel(0, 0, 0, 0));
    rd(0, 20, 0); tick; chk("top_y20", pel, exp_pel(0, 0, 12, 0));
    cur_y = 9'd7;
    rd(1, 45, 0); tick; chk("bot_y45", pel, exp_pel(0, 1, 39, 0));
    cur_y = 9'd0; total_y = 9'd0;
    rd(0, 45, 0); tick; chk("top_over_bot", pel, exp_pel(0, 0, 37, 0));
    cur_y = 9'd1; total_y = 9'd7;
`ifdef FETCH_CHROMA_XCLAMP_EN
    rd(0, 10, 44); tick; chk("x44", pel, 64'hBEC1C4C7CACDD0D3);
`else
    rd(0, 10, 44); tick; chk("x44", pel, 64'hCACDD0D300000000);
`endif
    rd(1, 30, 41); tick; chk("x41", pel, exp_pel(0, 1, 30, 41));

    for (int i = 0; i < 3; i++) begin
      rd(0, i, 0);
      ld_valid = 1'b1; ld_addr = 6'(i); tmp = row3(1, i); ld_data = tmp[1151:384];
      tick;
      chk("b2b_valid", 64'(valid), 64'h1);
      chk("b2b_pel", pel, exp_pel(0, 0, i, 0));
    end
    rden = 1'b0; ld_valid = 1'b0;
    tick;
    chk("b2b_valid_end", 64'(valid), 64'h0);
    chk("b2b_err", 64'(rd_err), 64'h0);

    start = 1'b1; done = 1'b1;
    tick;
    start = 1'b0; done = 1'b0;
    chk("sd_ready", 64'(ready), 64'h1);
    chk("sd_load_bank", 64'(load_bank), 64'h0);
    rd(0, 1, 0); tick; rden = 1'b0;
    chk("sd_swapped_data", pel, exp_pel(1, 0, 1, 0));
    chk("sd_err_clean", 64'(rd_err), 64'h0);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("nodone_ready", 64'(ready), 64'h0);
    rd(1, 2, 0); tick; rden = 1'b0;
    chk("notready_valid", 64'(valid), 64'h1);
    chk("notready_pel", pel, exp_pel(0, 1, 2, 0));
    chk("notready_err", 64'(rd_err), 64'h1);
    tick; tick;
    chk("err_sticky", 64'(rd_err), 64'h1);

    rst = 1'b1; tick; rst = 1'b0; tick;
    chk("rst2_err", 64'(rd_err), 64'h0);
    chk("rst2_ready", 64'(ready), 64'h0);
    chk("rst2_pel", pel, 64'h0);
    ld_valid = 1'b1; ld_addr = 6'd50; tick; ld_valid = 1'b0;
    chk("bad_addr_err", 64'(rd_err), 64'h1);

    ld_valid3 = 1'b1; ld_addr3 = 6'd4; ld_data3 = row3(2, 4); tick;
    ld_valid3 = 1'b0; done3 = 1'b1; tick;
    done3 = 1'b0; start3 = 1'b1; tick;
    start3 = 1'b0;
    rden3 = 1'b1; sel3 = 2'd2; y3 = 6'd4; x3 = 6'd3; tick;
    chk("nch3_sel2", pel3, exp_pel(2, 2, 4, 3));
    chk("nch3_sel2_err", 64'(rd_err3), 64'h0);
    sel3 = 2'd3; tick; rden3 = 1'b0;
    chk("nch3_sel3_valid", 64'(valid3), 64'h1);
    chk("nch3_sel3_pel", pel3, 64'h0);
    chk("nch3_sel3_err", 64'(rd_err3), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
